// File: rtl/lsu_wb.sv
// lsu_wb: final LSU stage. Waits for load data, extracts and extends the
// addressed byte/halfword/word, and drives the register-file write port.
// Misaligned loads are flagged without waiting, and a load whose read
// response never arrives is abandoned after a bounded wait.
module lsu_wb #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_load_in,
    input  logic              zero_ext_in,
    input  logic              is_nop_in,
    input  logic [1:0]        size_in,
    input  logic [4:0]        rd_in,
    input  logic [1:0]        addr_lo_in,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_out,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              align_err,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rf_we;
    logic [4:0]          r_rf_waddr;
    logic [DATA_W-1:0]   r_rf_wdata;
    logic                r_align_err;
    logic                r_timeout_err;

    logic                w_load_v;
    logic                w_misaligned;
    logic                w_load_ok;
    logic                w_capture;
    logic                w_rd_nz;
    logic [7:0]          w_lane [4];
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_ext;

    // Split the low 32 bits of the response into its four byte lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_load_v  = is_load_in & ~is_nop_in;
    assign w_load_ok = w_load_v & ~w_misaligned;
    assign w_rd_nz   = (rd_in != 5'd0);

    // Alignment check: halfwords need an even address, words (and the 11
    // encoding, which behaves as a word) need a word-aligned address.
    always_comb begin
        w_misaligned = 1'b0;
        case (size_in)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = addr_lo_in[0];
            default: w_misaligned = (addr_lo_in != 2'b00);
        endcase
    end

    // Data is accepted either in the same cycle as an aligned load in IDLE
    // or later while waiting; inputs are held stable during the wait.
    assign w_capture = ((r_state == S_IDLE) & w_load_ok & mem_rvalid) |
                       ((r_state == S_WAIT) & mem_rvalid);

    // Select and extend the addressed field of the little-endian word.
    always_comb begin
        w_byte = w_lane[addr_lo_in];
        w_half = addr_lo_in[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};
        w_ext  = mem_rdata;
        case (size_in)
            2'b00:   w_ext = {{(DATA_W-8){~zero_ext_in & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{(DATA_W-16){~zero_ext_in & w_half[15]}}, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    // Upstream is held only while an aligned load still lacks its data.
    always_comb begin
        stall_out = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE:  stall_out = w_load_ok & ~mem_rvalid;
                S_WAIT:  stall_out = ~mem_rvalid;
                default: stall_out = 1'b0;
            endcase
        end
    end

    // Control FSM, wait counter and registered write-port/error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rf_we       <= 1'b0;
            r_rf_waddr    <= 5'd0;
            r_rf_wdata    <= '0;
            r_align_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_rf_we     <= w_capture & w_rd_nz;
            r_align_err <= (r_state == S_IDLE) & w_load_v & w_misaligned;
            if (w_capture && w_rd_nz) begin
                r_rf_waddr <= rd_in;
                r_rf_wdata <= w_ext;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_load_ok && !mem_rvalid) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_TIMEOUT) begin
                        // Flag becomes visible during the ERR cycle itself.
                        r_state       <= S_ERR;
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign align_err   = r_align_err;
    assign timeout_err = r_timeout_err;

endmodule
